// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying the words read out of the block RAM.
interface bram_stream_reader_if #(
   parameter int DWIDTH = 32
);
   logic              m_valid;
   logic              m_ready;
   logic [DWIDTH-1:0] m_data;
   logic              m_last;

   modport master (output m_valid, m_data, m_last, input m_ready);
   modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a block of words from a 1-cycle-latency BRAM port and streams them out,
// throttling issue so a 2-entry buffer can always absorb every returned word.
module bram_stream_reader #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH:0]   length,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_din,
   input  logic [DWIDTH-1:0] mem_dout,
   bram_stream_reader_if.master m
);
   localparam logic [AWIDTH:0]   ONE   = 1;
   localparam logic [AWIDTH-1:0] ONE_A = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [AWIDTH:0]   len_q, issued, popped;
   logic [DWIDTH-1:0] buf_q [2];
   logic [1:0]        buf_count;
   logic [2:0]        occ;
   logic              rd_ptr, wr_ptr, inflight;
   logic              pop, last_pop, go_cmd, zero_cmd;

   assign mem_we    = 1'b0;
   assign mem_din   = '0;
   assign m.m_valid = (buf_count != 2'd0);
   assign m.m_data  = buf_q[rd_ptr];

   assign pop      = m.m_valid & m.m_ready;
   assign last_pop = pop && (popped == len_q - ONE);
   assign go_cmd   = (state == IDLE) && start && (length != '0);
   assign zero_cmd = (state == IDLE) && start && (length == '0);
   // Slots committed after this cycle's pop; an issue is allowed only if one stays free.
   assign occ      = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_cmd) state_nxt = RUN;
         RUN:     if (mem_en && (issued + ONE == len_q)) state_nxt = DRAIN;
         DRAIN:   if (last_pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      mem_en = (state == RUN) && (issued < len_q) && (occ < 3'd2);
      m.m_last = m.m_valid && (popped == len_q - ONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done      <= 1'b0;
         inflight  <= 1'b0;
         len_q     <= '0;
         issued    <= '0;
         popped    <= '0;
         mem_addr  <= '0;
         buf_q[0]  <= '0;
         buf_q[1]  <= '0;
         buf_count <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
      end else begin
         done      <= last_pop | zero_cmd;
         inflight  <= mem_en;
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
         if (go_cmd) begin
            len_q    <= length;
            mem_addr <= base_addr;
            issued   <= '0;
            popped   <= '0;
         end
         if (mem_en) begin
            mem_addr <= mem_addr + ONE_A;
            issued   <= issued + ONE;
         end
         if (pop) begin
            popped <= popped + ONE;
            rd_ptr <= ~rd_ptr;
         end
         // RAM output is registered, so the word issued last cycle is on mem_dout now.
         if (inflight) begin
            buf_q[wr_ptr] <= mem_dout;
            wr_ptr        <= ~wr_ptr;
         end
      end
   end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized-backpressure bench for bram_stream_reader with a queue-free beat/issue model.
module tb_bram_stream_reader;
   logic        clk, rst, start;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        busy, done, mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din, mem_dout;
   logic [31:0] mem [1024];

   bram_stream_reader_if #(.DWIDTH(32)) s ();

   bram_stream_reader #(.AWIDTH(10), .DWIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .m(s)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int exp_base, exp_len, beat, iss, done_cnt, last_cnt, last_hs, first_hs, first_valid, start_cyc;
   int mode = 0;
   bit chk_en = 0, zero_mode = 0, stalled_prev = 0;
   logic [31:0] prev_data;
   logic [31:0] got_data [16];
   logic [9:0]  got_addr [16];
   logic [5:0]  pat = 6'b101001;
   int pi = 0;

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   initial begin
      s.m_ready = 0;
      forever begin
         @(posedge clk); #2;
         case (mode)
            0: s.m_ready = 1;
            1: begin s.m_ready = pat[pi % 6]; pi++; end
            2: s.m_ready = 1'($urandom_range(0, 1));
            default: s.m_ready = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst || !chk_en) stalled_prev = 0;
      else begin
         chk("occupancy", 64'((iss - beat) <= 2), 1);
         chk("valid_needs_busy", 64'(!s.m_valid || busy), 1);
         if (zero_mode) chk("zero_busy", {busy, mem_en, s.m_valid}, 0);
         if (stalled_prev) begin
            chk("stall_valid", s.m_valid, 1);
            chk("stall_data", s.m_data, prev_data);
         end
         if (mem_en) begin
            chk("mem_addr", mem_addr, (exp_base + iss) % 1024);
            chk("issue_in_range", 64'(iss < exp_len), 1);
            chk("write_side_idle", {mem_we, mem_din}, 0);
            if (iss < 16) got_addr[iss] = mem_addr;
            iss++;
         end
         if (s.m_valid) begin
            chk("m_last", s.m_last, 64'(beat == exp_len - 1));
            if (first_valid < 0) first_valid = cyc;
            if (s.m_ready) begin
               chk("beat_in_range", 64'(beat < exp_len), 1);
               chk("m_data", s.m_data, mem[(exp_base + beat) % 1024]);
               if (beat < 16) got_data[beat] = s.m_data;
               if (s.m_last) last_cnt++;
               if (beat == 0) first_hs = cyc;
               last_hs = cyc;
               beat++;
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_time", cyc, zero_mode ? start_cyc + 1 : last_hs + 1);
         end
         stalled_prev = s.m_valid && !s.m_ready;
         prev_data = s.m_data;
      end
   end

   task automatic step(int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic cmd(logic [9:0] b, logic [10:0] l, bit model_it);
      if (model_it) begin
         exp_base = b; exp_len = l; beat = 0; iss = 0;
         done_cnt = 0; last_cnt = 0; first_valid = -1; start_cyc = cyc;
      end
      start = 1; base_addr = b; length = l;
      step(1);
      start = 0;
   endtask

   task automatic wait_done(int maxc);
      int n = 0;
      while (done_cnt == 0 && n < maxc) begin
         @(negedge clk); #1;
         n++;
      end
      chk("done_seen", 64'(done_cnt != 0), 1);
      chk("idle_after_done", busy, 0);
   endtask

   task automatic reset_outs(string nm);
      chk(nm, {busy, done, mem_en, s.m_valid, s.m_last, mem_addr, s.m_data}, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
      rst = 1; start = 0; base_addr = 0; length = 0;
      exp_base = 0; exp_len = 0; beat = 0; iss = 0; done_cnt = 0; last_cnt = 0;
      first_valid = -1; first_hs = 0; last_hs = 0; start_cyc = 0;
      #1 reset_outs("reset_state");
      step(2);
      rst = 0; chk_en = 1;

      // basic run, full throughput
      mode = 0;
      cmd(10'h010, 11'd4, 1);
      wait_done(50);
      chk("t1_beats", beat, 4);
      chk("t1_last_cnt", last_cnt, 1);
      chk("t1_latency", first_valid - start_cyc, 3);
      chk("t1_back_to_back", last_hs - first_hs, 3);
      chk("t1_first_word", got_data[0], 32'hA000_0010);
      chk("t1_last_word", got_data[3], 32'hA000_0013);
      step(3);
      chk("t1_single_done", done_cnt, 1);

      // same command under toggling backpressure
      mode = 1;
      cmd(10'h010, 11'd4, 1);
      wait_done(100);
      chk("t2_beats", beat, 4);
      chk("t2_word2", got_data[2], 32'hA000_0012);
      step(3);

      // address wrap
      mode = 0;
      cmd(10'h3FE, 11'd4, 1);
      wait_done(50);
      chk("t3_addrs", {got_addr[0], got_addr[1], got_addr[2], got_addr[3]}, {10'h3FE, 10'h3FF, 10'h000, 10'h001});
      chk("t3_wrap_word", got_data[1], 32'hA000_03FF);
      chk("t3_wrap_word2", got_data[2], 32'hA000_0000);
      step(3);

      // zero length
      zero_mode = 1;
      cmd(10'h020, 11'd0, 1);
      step(5);
      chk("t4_zero_done", done_cnt, 1);
      chk("t4_zero_beats", beat + iss, 0);
      zero_mode = 0;

      // start while busy is ignored
      mode = 2;
      cmd(10'h040, 11'd8, 1);
      step(2);
      cmd(10'h050, 11'd3, 0);
      wait_done(200);
      step(3);
      chk("t5_beats", beat, 8);
      chk("t5_done_cnt", done_cnt, 1);

      // reset mid-transfer with stalled consumer
      mode = 0;
      cmd(10'h080, 11'd8, 1);
      n = 0;
      while (beat < 2 && n < 50) begin @(posedge clk); #1; n++; end
      chk("t6_reached_beat2", 64'(beat >= 2), 1);
      mode = 3;
      repeat (3) @(posedge clk);
      #3;
      chk_en = 0; rst = 1;
      #1 reset_outs("t6_async_reset");
      beat = 0; iss = 0; done_cnt = 0; exp_len = 0;
      @(posedge clk); @(posedge clk); #2;
      rst = 0; mode = 0; chk_en = 1;
      step(3);
      chk("t6_no_done", done_cnt, 0);
      cmd(10'h100, 11'd2, 1);
      wait_done(50);
      chk("t6_beats", beat, 2);
      chk("t6_words", {got_data[0], got_data[1]}, {32'hA000_0100, 32'hA000_0101});
      chk("t6_last_cnt", last_cnt, 1);
      step(3);

      // full sweep with random backpressure
      mode = 2;
      cmd(10'h200, 11'd1024, 1);
      wait_done(10000);
      chk("t7_beats", beat, 1024);
      chk("t7_issues", iss, 1024);
      chk("t7_last_cnt", last_cnt, 1);
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
